// File: rtl/topk_stream_sorter_pkg.sv
// Shared definitions for the top-K stream sorter: mode encodings, beats per mode
// and the control FSM state type.
package topk_sorter_pkg;

  localparam logic [1:0] M_QPSK  = 2'b00;
  localparam logic [1:0] M_QAM16 = 2'b01;
  localparam logic [1:0] M_QAM64 = 2'b10;
  localparam logic [1:0] M_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_INSERT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [4:0] beats_of(input logic [1:0] m);
    case (m)
      M_QAM16: return 5'd4;
      M_QAM64: return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/topk_stream_sorter_if.sv
// Beat input and ranked-list output bundle of the top-K stream sorter.
interface topk_stream_sorter_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int K     = 4,
  parameter int IDXW  = 6
);
  logic                   start;
  logic [1:0]             M;
  logic [LANES*WIDTH-1:0] din;
  logic                   in_valid;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [K*WIDTH-1:0]     y;
  logic [K*IDXW-1:0]      y_idx;
  logic [K-1:0]           y_vld;
  logic                   done;
  logic                   busy;
  logic                   err;

  modport slave (
    input  start, M, din, in_valid, out_ready,
    output in_ready, out_valid, y, y_idx, y_vld, done, busy, err
  );

  modport master (
    output start, M, din, in_valid, out_ready,
    input  in_ready, out_valid, y, y_idx, y_vld, done, busy, err
  );
endinterface

// File: rtl/topk_stream_sorter_insert_slot.sv
// One entry of the ranked list. Define SORTER_ASCENDING_EN to rank smallest first.
module topk_insert_slot #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_ins,
  input  logic [WIDTH-1:0] i_val,
  input  logic [IDXW-1:0]  i_idx,
  input  logic             i_up_take,
  input  logic [WIDTH-1:0] i_up_val,
  input  logic [IDXW-1:0]  i_up_idx,
  input  logic             i_up_vld,
  output logic             o_take,
  output logic [WIDTH-1:0] o_val,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_vld
);

  logic [WIDTH-1:0] r_val;
  logic [IDXW-1:0]  r_idx;
  logic             r_vld;
  logic             w_better;

  // Strict compare keeps equal values below the earlier entry, so ties stay stable.
`ifdef SORTER_ASCENDING_EN
  assign w_better = (i_val < r_val);
`else
  assign w_better = (i_val > r_val);
`endif

  assign o_take = !r_vld || w_better;

  // When the slot above also yields, the new sample lands higher and this slot shifts down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= '0;
      r_idx <= '0;
      r_vld <= 1'b0;
    end else if (i_clr) begin
      r_val <= '0;
      r_idx <= '0;
      r_vld <= 1'b0;
    end else if (i_ins && o_take) begin
      if (i_up_take) begin
        r_val <= i_up_val;
        r_idx <= i_up_idx;
        r_vld <= i_up_vld;
      end else begin
        r_val <= i_val;
        r_idx <= i_idx;
        r_vld <= 1'b1;
      end
    end
  end

  assign o_val = r_val;
  assign o_idx = r_idx;
  assign o_vld = r_vld;

endmodule

// File: rtl/topk_stream_sorter.sv
// Streaming top-K sorter: one lane inserted per cycle into K parallel slots.
// Optional macro SORTER_ASCENDING_EN (in topk_insert_slot) ranks smallest first.
module topk_stream_sorter
  import topk_sorter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int K     = 4,
  parameter int IDXW  = 6
) (
  input logic               clk,
  input logic               rst,
  topk_stream_sorter_if.slave sif
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_mode;
  logic [3:0]             r_beat_cnt;
  logic [LW-1:0]          r_lane_cnt;
  logic [LANES*WIDTH-1:0] r_hold;
  logic                   r_done_seen;
  logic                   r_err;

  logic             w_start_ok;
  logic             w_clr;
  logic             w_ins;
  logic             w_last_lane;
  logic             w_last_beat;
  logic [WIDTH-1:0] w_sample;
  logic [IDXW-1:0]  w_ins_idx;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;
  logic             w_done;

  assign w_start_ok  = sif.start && (sif.M != M_RSVD);
  assign w_clr       = (r_state == S_IDLE) && w_start_ok;
  assign w_ins       = (r_state == S_INSERT);
  assign w_last_lane = (r_lane_cnt == LW'(LANES - 1));
  assign w_last_beat = ({1'b0, r_beat_cnt} == (beats_of(r_mode) - 5'd1));
  assign w_ins_idx   = IDXW'(r_beat_cnt) * IDXW'(LANES) + IDXW'(r_lane_cnt);

  always_comb begin
    w_sample = '0;
    for (int l = 0; l < LANES; l++) begin
      if (r_lane_cnt == LW'(l)) w_sample = r_hold[l*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_next = S_LOAD;
      S_LOAD:   if (sif.in_valid) w_next = S_INSERT;
      S_INSERT: if (w_last_lane) w_next = w_last_beat ? S_DONE : S_LOAD;
      S_DONE:   if (sif.out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == S_LOAD);
    w_out_valid = (r_state == S_DONE);
    w_busy      = (r_state != S_IDLE);
    w_done      = (r_state == S_DONE) && !r_done_seen;
  end

  // Frame counters, beat holding register and the registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= M_QPSK;
      r_beat_cnt  <= '0;
      r_lane_cnt  <= '0;
      r_hold      <= '0;
      r_done_seen <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done_seen <= (r_state == S_DONE);
      r_err       <= (r_state == S_IDLE) && sif.start && (sif.M == M_RSVD);
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_mode     <= sif.M;
            r_beat_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (sif.in_valid) begin
            r_hold     <= sif.din;
            r_lane_cnt <= '0;
          end
        end
        S_INSERT: begin
          r_lane_cnt <= r_lane_cnt + 1'b1;
          if (w_last_lane && !w_last_beat) r_beat_cnt <= r_beat_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  logic [WIDTH-1:0] w_val [K];
  logic [IDXW-1:0]  w_idx [K];
  logic [K-1:0]     w_vld;
  logic [K-1:0]     w_take;

  for (genvar gi = 0; gi < K; gi++) begin : g_slot
    logic             w_up_take;
    logic [WIDTH-1:0] w_up_val;
    logic [IDXW-1:0]  w_up_idx;
    logic             w_up_vld;

    if (gi == 0) begin : g_head
      assign w_up_take = 1'b0;
      assign w_up_val  = '0;
      assign w_up_idx  = '0;
      assign w_up_vld  = 1'b0;
    end else begin : g_body
      assign w_up_take = w_take[gi-1];
      assign w_up_val  = w_val[gi-1];
      assign w_up_idx  = w_idx[gi-1];
      assign w_up_vld  = w_vld[gi-1];
    end

    topk_insert_slot #(
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_ins     (w_ins),
      .i_val     (w_sample),
      .i_idx     (w_ins_idx),
      .i_up_take (w_up_take),
      .i_up_val  (w_up_val),
      .i_up_idx  (w_up_idx),
      .i_up_vld  (w_up_vld),
      .o_take    (w_take[gi]),
      .o_val     (w_val[gi]),
      .o_idx     (w_idx[gi]),
      .o_vld     (w_vld[gi])
    );
  end

  logic [K*WIDTH-1:0] w_y;
  logic [K*IDXW-1:0]  w_y_idx;

  always_comb begin
    w_y     = '0;
    w_y_idx = '0;
    for (int s = 0; s < K; s++) begin
      w_y[s*WIDTH +: WIDTH]   = w_val[s];
      w_y_idx[s*IDXW +: IDXW] = w_idx[s];
    end
  end

  assign sif.in_ready  = w_in_ready;
  assign sif.out_valid = w_out_valid;
  assign sif.busy      = w_busy;
  assign sif.done      = w_done;
  assign sif.err       = r_err;
  assign sif.y         = w_y;
  assign sif.y_idx     = w_y_idx;
  assign sif.y_vld     = w_vld;

endmodule

// File: tb/tb_topk_stream_sorter.sv
// Bench for topk_stream_sorter: constant vectors, corner sequences, randomized frames.
module tb_topk_stream_sorter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  int   done_cnt_a = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  topk_stream_sorter_if #(.WIDTH(8), .LANES(4), .K(4), .IDXW(6)) ifa ();
  topk_stream_sorter_if #(.WIDTH(8), .LANES(4), .K(8), .IDXW(6)) ifb ();

  topk_stream_sorter #(.WIDTH(8), .LANES(4), .K(4), .IDXW(6)) u_a (
    .clk (clk), .rst (rst), .sif (ifa)
  );
  topk_stream_sorter #(.WIDTH(8), .LANES(4), .K(8), .IDXW(6)) u_b (
    .clk (clk), .rst (rst), .sif (ifb)
  );

  always @(negedge clk) if (ifa.done) done_cnt_a++;

  typedef struct packed {
    logic [1:0]        m;
    logic [15:0][31:0] bt;
    logic [31:0]       ey;
    logic [23:0]       ei;
    logic [3:0]        ev;
    logic [7:0]        lat;
  } vec_t;

  vec_t vec [3];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    nchk++;
    nfail++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  function automatic int beats_tb(input logic [1:0] m);
    return (m == 2'd0) ? 1 : (m == 2'd1) ? 4 : 16;
  endfunction

  function automatic bit ranks_above(input int a, input int b);
`ifdef SORTER_ASCENDING_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  // Stable insertion sort of the whole frame, then take the first four.
  function automatic void model(input logic [1:0] m, input logic [15:0][31:0] bt,
                                output logic [31:0] ey, output logic [23:0] ei,
                                output logic [3:0] ev);
    int lv[$];
    int li[$];
    int s, pos;
    bit found;
    for (int b = 0; b < beats_tb(m); b++) begin
      for (int l = 0; l < 4; l++) begin
        s = int'(bt[b][l*8 +: 8]);
        pos = lv.size();
        found = 1'b0;
        for (int j = 0; j < lv.size(); j++) begin
          if (!found && ranks_above(s, lv[j])) begin
            pos = j;
            found = 1'b1;
          end
        end
        lv.insert(pos, s);
        li.insert(pos, b * 4 + l);
      end
    end
    ey = '0; ei = '0; ev = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < lv.size()) begin
        ey[k*8 +: 8] = 8'(lv[k]);
        ei[k*6 +: 6] = 6'(li[k]);
        ev[k]        = 1'b1;
      end
    end
  endfunction

  task automatic run_a(input logic [1:0] m, input logic [15:0][31:0] bt,
                       input int stall, input int odly,
                       output logic [31:0] gy, output logic [23:0] gi,
                       output logic [3:0] gv, output int lat, output int dcnt);
    int t0, w;
    done_cnt_a = 0;
    ifa.M = m;
    ifa.start = 1'b1;
    tick;
    t0 = cyc;
    ifa.start = 1'b0;
    ifa.M = 2'b11;
    for (int b = 0; b < beats_tb(m); b++) begin
      if (b == 0 && stall > 0) begin
        ifa.in_valid = 1'b0;
        for (int s = 0; s < stall; s++) begin
          chk("stall_in_ready", 64'(ifa.in_ready), 64'd1);
          tick;
        end
      end
      ifa.in_valid = 1'b1;
      ifa.din = bt[b];
      w = 0;
      while (!ifa.in_ready && w < 50) begin tick; w++; end
      if (w >= 50) timeout_fail("in_ready_wait");
      tick;
      ifa.in_valid = 1'b0;
      ifa.din = $urandom;
    end
    w = 0;
    while (!ifa.out_valid && w < 100) begin tick; w++; end
    if (w >= 100) timeout_fail("out_valid_wait");
    lat = cyc - t0;
    gy = ifa.y; gi = ifa.y_idx; gv = ifa.y_vld;
    for (int d = 0; d < odly; d++) begin
      tick;
      chk("hold_y", 64'(ifa.y), 64'(gy));
      chk("hold_out_valid", 64'(ifa.out_valid), 64'd1);
    end
    ifa.out_ready = 1'b1;
    tick;
    ifa.out_ready = 1'b0;
    ifa.M = 2'b00;
    chk("busy_after_accept", 64'(ifa.busy), 64'd0);
    dcnt = done_cnt_a;
  endtask

  logic [31:0]       gy, ey;
  logic [23:0]       gi, ei;
  logic [3:0]        gv, ev;
  int                lat, dcnt, w;
  logic [15:0][31:0] rbt;
  logic [1:0]        rm;

  initial begin
    vec[0] = '0;
    vec[0].m = 2'd0; vec[0].bt[0] = {8'd0, 8'd1, 8'd20, 8'd10};
    vec[0].ey = {8'd0, 8'd1, 8'd10, 8'd20}; vec[0].ei = {6'd3, 6'd2, 6'd0, 6'd1};
    vec[0].ev = 4'hF; vec[0].lat = 8'd5;
    vec[1] = '0;
    vec[1].m = 2'd1;
    vec[1].bt[0] = {8'd0, 8'd1, 8'd20, 8'd10};
    vec[1].bt[1] = {8'd22, 8'd8, 8'd3, 8'd40};
    vec[1].bt[2] = {8'd6, 8'd120, 8'd4, 8'd100};
    vec[1].bt[3] = {8'd15, 8'd91, 8'd86, 8'd122};
    vec[1].ey = {8'd91, 8'd100, 8'd120, 8'd122}; vec[1].ei = {6'd14, 6'd8, 6'd10, 6'd12};
    vec[1].ev = 4'hF; vec[1].lat = 8'd20;
    vec[2] = '0;
    vec[2].m = 2'd0; vec[2].bt[0] = 32'h07070707;
    vec[2].ey = 32'h07070707; vec[2].ei = {6'd3, 6'd2, 6'd1, 6'd0};
    vec[2].ev = 4'hF; vec[2].lat = 8'd5;

    ifa.start = 0; ifa.M = 0; ifa.din = 0; ifa.in_valid = 0; ifa.out_ready = 0;
    ifb.start = 0; ifb.M = 0; ifb.din = 0; ifb.in_valid = 0; ifb.out_ready = 0;
    repeat (3) tick;
    chk("rst_in_ready", 64'(ifa.in_ready), 64'd0);
    chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_done", 64'(ifa.done), 64'd0);
    chk("rst_busy", 64'(ifa.busy), 64'd0);
    chk("rst_err", 64'(ifa.err), 64'd0);
    chk("rst_y", 64'(ifa.y), 64'd0);
    chk("rst_y_idx", 64'(ifa.y_idx), 64'd0);
    chk("rst_y_vld", 64'(ifa.y_vld), 64'd0);
    chk("rst_b_y_vld", 64'(ifb.y_vld), 64'd0);
    rst = 1'b0;
    tick;

    for (int v = 0; v < 3; v++) begin
      run_a(vec[v].m, vec[v].bt, 0, 0, gy, gi, gv, lat, dcnt);
      chk($sformatf("vec%0d_y", v), 64'(gy), 64'(vec[v].ey));
      chk($sformatf("vec%0d_idx", v), 64'(gi), 64'(vec[v].ei));
      chk($sformatf("vec%0d_vld", v), 64'(gv), 64'(vec[v].ev));
      chk($sformatf("vec%0d_latency", v), 64'(lat), 64'(vec[v].lat));
      chk($sformatf("vec%0d_done_once", v), 64'(dcnt), 64'd1);
    end

    // Backpressure on both sides of the frame.
    run_a(vec[0].m, vec[0].bt, 3, 5, gy, gi, gv, lat, dcnt);
    chk("bp_y", 64'(gy), 64'(vec[0].ey));
    chk("bp_idx", 64'(gi), 64'(vec[0].ei));
    chk("bp_done_once", 64'(dcnt), 64'd1);

    // Reserved mode.
    ifa.M = 2'b11; ifa.start = 1'b1;
    tick;
    ifa.start = 1'b0; ifa.M = 2'b00;
    chk("err_pulse", 64'(ifa.err), 64'd1);
    chk("err_busy", 64'(ifa.busy), 64'd0);
    tick;
    chk("err_clear", 64'(ifa.err), 64'd0);
    chk("err_busy_after", 64'(ifa.busy), 64'd0);

    // Reset during beat 2 of a QAM16 frame.
    ifa.M = 2'd1; ifa.start = 1'b1;
    tick;
    ifa.start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      ifa.in_valid = 1'b1; ifa.din = vec[1].bt[b];
      w = 0;
      while (!ifa.in_ready && w < 50) begin tick; w++; end
      if (w >= 50) timeout_fail("mid_rst_in_ready");
      tick;
      ifa.in_valid = 1'b0;
    end
    tick; tick;
    chk("mid_pre_vld", 64'(ifa.y_vld), 64'hF);
    rst = 1'b1;
    #1;
    chk("mid_rst_y", 64'(ifa.y), 64'd0);
    chk("mid_rst_idx", 64'(ifa.y_idx), 64'd0);
    chk("mid_rst_vld", 64'(ifa.y_vld), 64'd0);
    chk("mid_rst_busy", 64'(ifa.busy), 64'd0);
    chk("mid_rst_in_ready", 64'(ifa.in_ready), 64'd0);
    tick;
    rst = 1'b0;
    tick;
    run_a(vec[0].m, vec[0].bt, 0, 0, gy, gi, gv, lat, dcnt);
    chk("post_rst_y", 64'(gy), 64'(vec[0].ey));
    chk("post_rst_idx", 64'(gi), 64'(vec[0].ei));

    // Underfill on the K=8 instance.
    ifb.M = 2'd0; ifb.start = 1'b1;
    tick;
    ifb.start = 1'b0;
    ifb.in_valid = 1'b1; ifb.din = vec[0].bt[0];
    tick;
    ifb.in_valid = 1'b0;
    w = 0;
    while (!ifb.out_valid && w < 50) begin tick; w++; end
    if (w >= 50) timeout_fail("b_out_valid_wait");
    chk("under_vld", 64'(ifb.y_vld), 64'h0F);
    chk("under_y", 64'(ifb.y), {32'h0, vec[0].ey});
    chk("under_idx", 64'(ifb.y_idx), {40'h0, vec[0].ei});
    ifb.out_ready = 1'b1;
    tick;
    ifb.out_ready = 1'b0;

    // Random frames against the reference model.
    for (int f = 0; f < 25; f++) begin
      rm = 2'($urandom_range(0, 2));
      rbt = '0;
      for (int b = 0; b < 16; b++)
        for (int l = 0; l < 4; l++) rbt[b][l*8 +: 8] = 8'($urandom_range(0, 31));
      model(rm, rbt, ey, ei, ev);
      run_a(rm, rbt, $urandom_range(0, 2), $urandom_range(0, 2), gy, gi, gv, lat, dcnt);
      chk($sformatf("rnd%0d_y", f), 64'(gy), 64'(ey));
      chk($sformatf("rnd%0d_idx", f), 64'(gi), 64'(ei));
      chk($sformatf("rnd%0d_vld", f), 64'(gv), 64'(ev));
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/topk_stream_sorter.md
Name: topk_stream_sorter

Overview:
- Parametrised successor to the fixed 4-input sorter in the V2V symbol-selection path.
- Streams LANES samples per beat. The modulation mode sets how many beats form one frame.
- Keeps a running top-K list, sorted descending, holding both values and their symbol indices.
- Presents the finished list through a valid/ready output handshake. It feeds the per-frame candidate-selection logic downstream.

Parameters:
- WIDTH, 8, sample width (unsigned).
- LANES, 4, samples per input beat.
- K, 4, number of ranked outputs (1..64).
- IDXW, 6, symbol-index width; must satisfy 2^IDXW >= 16*LANES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame-start pulse; honoured only in IDLE.
- M  in  2  mode: 00 QPSK (1 beat), 01 QAM16 (4 beats), 10 QAM64 (16 beats), 11 reserved.
- din  in  LANES*WIDTH  beat data; lane0 = [WIDTH-1:0] (legacy d1), lane1 = d2, and so on.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- out_valid  out  1  ranked list valid; held until out_ready.
- out_ready  in  1  consumer accepts the list.
- y  out  K*WIDTH  ranked values; slot0 = [WIDTH-1:0] = best.
- y_idx  out  K*IDXW  symbol index per slot.
- y_vld  out  K  slot-occupied mask.
- done  out  1  one-cycle pulse on entry to DONE.
- busy  out  1  high when not in IDLE.
- err  out  1  one-cycle pulse when start arrives with M=11.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - in_ready, out_valid, done, busy, err = 0.
  - y, y_idx = 0.
  - y_vld = 0.
  - All beat and lane counters = 0.
- FSM states: IDLE, LOAD, INSERT, DONE.
- IDLE:
  - start with M!=11: latch M, clear the list (y_vld=0), set beat_cnt=0, go to LOAD.
  - start with M=11: pulse err, stay in IDLE.
  - M is sampled only at start; later changes to M are ignored until the next frame.
- LOAD:
  - in_ready=1.
  - On handshake: capture din into a holding register, set lane_cnt=0, go to INSERT.
- INSERT:
  - in_ready=0. One lane is inserted per cycle, lane_cnt from 0 to LANES-1.
  - Symbol index of each insert = beat_cnt*LANES + lane_cnt.
  - Insertion uses a parallel compare-and-shift across all K slots.
  - A new value goes above a slot only if strictly greater. Ties keep the earlier index higher (stable).
  - The displaced tail entry is dropped when the list is full.
  - Empty slots always accept.
  - After lane LANES-1: if beat_cnt == beats(M)-1, go to DONE; otherwise beat_cnt++ and go to LOAD.
- DONE:
  - out_valid=1. done pulses on the first DONE cycle only.
  - y, y_idx and y_vld stay stable until out_ready, then the FSM returns to IDLE.
  - A start arriving while in DONE is ignored.
- Timing:
  - Each beat takes 1 accept cycle plus LANES insert cycles.
  - out_valid rises LANES cycles after the final beat is accepted.
  - Minimum frame length: beats*(LANES+1) cycles.
- Fewer samples than K (for example QPSK with K=8): the unfilled slots keep y_vld=0, y=0, y_idx=0.
- start while busy is ignored (no restart).
- Reset mid-frame aborts the frame with no partial output.

Optional Feature:
- Macro: SORTER_ASCENDING_EN.
- Defined: the list ranks smallest first. The comparison becomes strictly-less, and ties stay stable as before.
- Undefined: descending ranking as specified above.

Decomposition:
- Shared package topk_sorter_pkg holds:
  - the mode encodings M_QPSK=2'b00, M_QAM16=2'b01, M_QAM64=2'b10, M_RSVD=2'b11;
  - the beats-per-mode function (1/4/16);
  - the FSM state typedef.
- One sub-module: topk_insert_slot, a single list slot. It holds value, index and valid; compares against the incoming sample; and takes either the incoming sample or its upper neighbour's entry.
- The top level instantiates K slots plus the FSM and counters.

Test Plan:
- QPSK, K=4, beat {d1=10,d2=20,d3=1,d4=0} -> y = 20,10,1,0; y_idx = 1,0,2,3; y_vld = 4'hF; done pulses once.
- QAM16, K=4, four beats {10,20,1,0},{40,3,8,22},{100,4,120,6},{122,86,91,15} -> y = 122,120,100,91; y_idx = 12,10,8,14; out_valid rises 20 cycles after start is accepted.
- Ties: QPSK with all lanes=7 -> y_idx = 0,1,2,3. Underfill: K=8 QPSK -> y_vld = 8'h0F, slots 4-7 are zero.
- Backpressure:
  - in_valid low for 3 cycles in LOAD -> no progress, in_ready stays high;
  - out_ready low for 5 cycles -> y held stable and done not re-pulsed.
- M=11 with start -> err pulses for 1 cycle, busy stays 0.
- Reset asserted mid-QAM16 (beat 2) -> all outputs 0 immediately; a following QPSK frame gives correct results.
